// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the handshaked instruction fetch stage.
// Holds the FSM state encoding and the error codes reported to decode.
package ifu_fetch_pkg;

  localparam int IFU_PC_W   = 64;
  localparam int IFU_INS_W  = 32;
  localparam int IFU_DATA_W = 64;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'b00,
    IFU_REQ  = 2'b01,
    IFU_WAIT = 2'b10,
    IFU_HOLD = 2'b11
  } ifuState_e;

  typedef logic [1:0] ifuErr_t;

  localparam ifuErr_t IFU_ERR_OK       = 2'b00;
  localparam ifuErr_t IFU_ERR_MISALIGN = 2'b01;
  localparam ifuErr_t IFU_ERR_FAULT    = 2'b10;

endpackage

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: takes a PC, reads 64-bit memory over valid/ready,
// selects the 32-bit word and holds it until decode accepts it.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int PC_W   = IFU_PC_W,
  parameter int INS_W  = IFU_INS_W,
  parameter int DATA_W = IFU_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pc_valid,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_pc_ready,
  input  logic              i_flush,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [PC_W-1:0]   o_mem_addr,
  input  logic              i_mem_rsp_valid,
  output logic              o_mem_rsp_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_rsp_err,
  output logic              o_ins_valid,
  input  logic              i_ins_ready,
  output logic [INS_W-1:0]  o_ins,
  output logic [PC_W-1:0]   o_ins_pc,
  output logic [1:0]        o_ins_err
);

  ifuState_e         r_state;
  ifuState_e         w_stateNext;
  logic              r_drop;
  logic              w_dropNext;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_memAddr;
  logic [INS_W-1:0]  r_ins;
  ifuErr_t           r_insErr;

  logic              w_pcFire;
  logic              w_insFire;
  logic              w_rspFire;
  logic              w_misaligned;
  logic [INS_W-1:0]  w_selWord;

  assign w_pcFire     = i_pc_valid && o_pc_ready;
  assign w_insFire    = o_ins_valid && i_ins_ready;
  assign w_rspFire    = i_mem_rsp_valid && o_mem_rsp_ready;
  assign w_misaligned = (i_pc[1:0] != 2'b00);
  assign w_selWord    = r_pc[2] ? i_mem_rdata[DATA_W-1:INS_W] : i_mem_rdata[INS_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IFU_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_drop  <= w_dropNext;
    end
  end

  // A PC can only be taken in IDLE or on the HOLD hand-off cycle, so both share one path.
  always_comb begin
    w_stateNext = r_state;
    w_dropNext  = r_drop;
    unique case (r_state)
      IFU_IDLE: begin
        if (w_pcFire) w_stateNext = w_misaligned ? IFU_HOLD : IFU_REQ;
      end
      IFU_REQ: begin
        if (i_flush) w_dropNext = 1'b1;
        if (i_mem_req_ready) w_stateNext = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (w_rspFire) begin
          w_dropNext  = 1'b0;
          w_stateNext = (r_drop || i_flush) ? IFU_IDLE : IFU_HOLD;
        end else if (i_flush) begin
          w_dropNext = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (i_flush)        w_stateNext = IFU_IDLE;
        else if (w_pcFire)  w_stateNext = w_misaligned ? IFU_HOLD : IFU_REQ;
        else if (w_insFire) w_stateNext = IFU_IDLE;
      end
      default: w_stateNext = IFU_IDLE;
    endcase
  end

  always_comb begin
    o_pc_ready      = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_rsp_ready = 1'b0;
    o_ins_valid     = 1'b0;
    unique case (r_state)
      IFU_IDLE: o_pc_ready      = !i_flush;
      IFU_REQ:  o_mem_req_valid = 1'b1;
      IFU_WAIT: o_mem_rsp_ready = 1'b1;
      IFU_HOLD: begin
        o_ins_valid = 1'b1;
        o_pc_ready  = i_ins_ready && !i_flush;
      end
      default: ;
    endcase
  end

  // Payload only moves on accepted PCs or kept responses, so it is stable through HOLD.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc      <= '0;
      r_memAddr <= '0;
      r_ins     <= '0;
      r_insErr  <= IFU_ERR_OK;
    end else begin
      if (w_pcFire) begin
        r_pc <= i_pc;
        if (w_misaligned) begin
          r_ins    <= '0;
          r_insErr <= IFU_ERR_MISALIGN;
        end else begin
          r_memAddr <= {i_pc[PC_W-1:3], 3'b000};
        end
      end
      if (r_state == IFU_WAIT && w_rspFire && !r_drop && !i_flush) begin
        r_ins    <= i_mem_rsp_err ? '0 : w_selWord;
        r_insErr <= i_mem_rsp_err ? IFU_ERR_FAULT : IFU_ERR_OK;
      end
    end
  end

  assign o_mem_addr = r_memAddr;
  assign o_ins      = r_ins;
  assign o_ins_pc   = r_pc;
  assign o_ins_err  = r_insErr;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: table of single fetches plus directed
// sequences for wait states, back-to-back issue, flush and reset.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic        i_pc_valid;
  logic [63:0] i_pc;
  logic        o_pc_ready;
  logic        i_flush;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [63:0] o_mem_addr;
  logic        i_mem_rsp_valid;
  logic        o_mem_rsp_ready;
  logic [63:0] i_mem_rdata;
  logic        i_mem_rsp_err;
  logic        o_ins_valid;
  logic        i_ins_ready;
  logic [31:0] o_ins;
  logic [63:0] o_ins_pc;
  logic [1:0]  o_ins_err;

  int nChecks = 0;
  int nFails  = 0;
  logic resetDone = 1'b0;
  logic prevReqHeld = 1'b0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] rdata;
    logic        rspErr;
    logic [31:0] expIns;
    logic [1:0]  expErr;
    logic [63:0] expAddr;
  } vec_t;

  vec_t vecs[7];

  ifu_fetch dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pc_valid(i_pc_valid), .i_pc(i_pc), .o_pc_ready(o_pc_ready),
    .i_flush(i_flush),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid), .o_mem_rsp_ready(o_mem_rsp_ready),
    .i_mem_rdata(i_mem_rdata), .i_mem_rsp_err(i_mem_rsp_err),
    .o_ins_valid(o_ins_valid), .i_ins_ready(i_ins_ready),
    .o_ins(o_ins), .o_ins_pc(o_ins_pc), .o_ins_err(o_ins_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Protocol watchdogs: valid outputs never X, and a pending request is never withdrawn.
  always @(posedge i_clk) prevReqHeld <= o_mem_req_valid && !i_mem_req_ready && !i_rst;

  always @(negedge i_clk) begin
    if (resetDone && !i_rst) begin
      if ($isunknown({o_pc_ready, o_mem_req_valid, o_mem_rsp_ready, o_ins_valid})) begin
        nFails++;
        $display("[TB] FAIL x_on_valid: valid outputs contain X");
      end
      if (prevReqHeld && !o_mem_req_valid) begin
        nFails++;
        $display("[TB] FAIL req_withdrawn: o_mem_req_valid fell without i_mem_req_ready");
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idleInputs();
    i_pc_valid      = 1'b0;
    i_pc            = '0;
    i_flush         = 1'b0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rdata     = '0;
    i_mem_rsp_err   = 1'b0;
    i_ins_ready     = 1'b0;
  endtask

  // Accept one PC from IDLE; leaves the DUT in REQ (or HOLD when misaligned).
  task automatic startFetch(input logic [63:0] pc);
    i_pc_valid = 1'b1;
    i_pc       = pc;
    #1;
    checkOutput("pc_ready_idle", {63'd0, o_pc_ready}, 64'd1);
    step();
    i_pc_valid = 1'b0;
    i_pc       = ~pc;
    #1;
  endtask

  // One complete zero-wait fetch from IDLE, including a HOLD stall cycle.
  task automatic applyStimulus(input vec_t v);
    i_mem_req_ready = 1'b1;
    startFetch(v.pc);
    if (v.expErr == IFU_ERR_MISALIGN) begin
      checkOutput("misalign_no_req", {63'd0, o_mem_req_valid}, 64'd0);
    end else begin
      checkOutput("req_valid", {63'd0, o_mem_req_valid}, 64'd1);
      checkOutput("mem_addr", o_mem_addr, v.expAddr);
      checkOutput("ins_valid_in_req", {63'd0, o_ins_valid}, 64'd0);
      step();
      i_mem_req_ready = 1'b0;
      #1;
      checkOutput("rsp_ready", {63'd0, o_mem_rsp_ready}, 64'd1);
      i_mem_rsp_valid = 1'b1;
      i_mem_rdata     = v.rdata;
      i_mem_rsp_err   = v.rspErr;
      step();
      i_mem_rsp_valid = 1'b0;
      i_mem_rdata     = ~v.rdata;
      i_mem_rsp_err   = 1'b0;
      #1;
    end
    i_mem_req_ready = 1'b0;
    checkOutput("ins_valid", {63'd0, o_ins_valid}, 64'd1);
    checkOutput("ins", {32'd0, o_ins}, {32'd0, v.expIns});
    checkOutput("ins_pc", o_ins_pc, v.pc);
    checkOutput("ins_err", {62'd0, o_ins_err}, {62'd0, v.expErr});
    step();
    checkOutput("hold_valid", {63'd0, o_ins_valid}, 64'd1);
    checkOutput("hold_ins_stable", {32'd0, o_ins}, {32'd0, v.expIns});
    checkOutput("hold_pc_stable", o_ins_pc, v.pc);
    i_ins_ready = 1'b1;
    step();
    i_ins_ready = 1'b0;
    checkOutput("after_accept_idle", {63'd0, o_ins_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] pcs[3];
    int got;
    int idx;
    logic pcFire;
    logic insFire;
    logic expectReq;

    vecs[0] = '{64'h8000_0004, 64'h0010_0093_0000_0013, 1'b0, 32'h0010_0093, IFU_ERR_OK, 64'h8000_0000};
    vecs[1] = '{64'h8000_0000, 64'h0010_0093_0000_0013, 1'b0, 32'h0000_0013, IFU_ERR_OK, 64'h8000_0000};
    vecs[2] = '{64'h1234_5678_9ABC_DEF8, 64'hDEAD_BEEF_CAFE_BABE, 1'b0, 32'hCAFE_BABE, IFU_ERR_OK, 64'h1234_5678_9ABC_DEF8};
    vecs[3] = '{64'h1234_5678_9ABC_DEFC, 64'hDEAD_BEEF_CAFE_BABE, 1'b0, 32'hDEAD_BEEF, IFU_ERR_OK, 64'h1234_5678_9ABC_DEF8};
    vecs[4] = '{64'h8000_0002, 64'h0, 1'b0, 32'h0, IFU_ERR_MISALIGN, 64'h0};
    vecs[5] = '{64'h8000_0001, 64'h0, 1'b0, 32'h0, IFU_ERR_MISALIGN, 64'h0};
    vecs[6] = '{64'h0000_0004, 64'h1111_2222_3333_4444, 1'b1, 32'h0, IFU_ERR_FAULT, 64'h0};

    idleInputs();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    resetDone = 1'b1;
    #1;
    checkOutput("rst_req_valid", {63'd0, o_mem_req_valid}, 64'd0);
    checkOutput("rst_rsp_ready", {63'd0, o_mem_rsp_ready}, 64'd0);
    checkOutput("rst_ins_valid", {63'd0, o_ins_valid}, 64'd0);
    checkOutput("rst_ins", {32'd0, o_ins}, 64'd0);
    checkOutput("rst_ins_pc", o_ins_pc, 64'd0);
    checkOutput("rst_ins_err", {62'd0, o_ins_err}, 64'd0);
    checkOutput("rst_mem_addr", o_mem_addr, 64'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Wait states: request stalled 3 cycles, response delayed 4 cycles.
    startFetch(64'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      checkOutput("ws_req_held", {63'd0, o_mem_req_valid}, 64'd1);
      checkOutput("ws_addr_held", o_mem_addr, 64'h8000_0000);
      step();
    end
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("ws_rsp_wait", {63'd0, o_mem_rsp_ready}, 64'd1);
      checkOutput("ws_no_ins", {63'd0, o_ins_valid}, 64'd0);
      step();
    end
    i_mem_rsp_valid = 1'b1;
    i_mem_rdata     = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    i_mem_rsp_valid = 1'b0;
    checkOutput("ws_ins", {32'd0, o_ins}, 64'hCCCC_DDDD);
    i_ins_ready = 1'b1;
    step();
    i_ins_ready = 1'b0;
    checkOutput("ws_single_ins", {63'd0, o_ins_valid}, 64'd0);
    step();
    checkOutput("ws_stays_idle", {63'd0, o_mem_req_valid | o_ins_valid}, 64'd0);

    // Back-to-back issue with decode and memory always ready.
    pcs[0] = 64'h0; pcs[1] = 64'h4; pcs[2] = 64'h8;
    got = 0; idx = 0; expectReq = 1'b0;
    i_ins_ready = 1'b1; i_mem_req_ready = 1'b1; i_mem_rsp_valid = 1'b1;
    i_pc_valid = 1'b1; i_pc = pcs[0];
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      i_mem_rdata = {32'h1000_0000 + o_mem_addr[31:0] + 32'd4, 32'h1000_0000 + o_mem_addr[31:0]};
      #1;
      pcFire  = i_pc_valid && o_pc_ready;
      insFire = o_ins_valid && i_ins_ready;
      if (insFire) begin
        checkOutput("b2b_ins", {32'd0, o_ins}, {32'd0, 32'h1000_0000 + pcs[got][31:0]});
        checkOutput("b2b_ins_pc", o_ins_pc, pcs[got]);
        got++;
        expectReq = pcFire;
      end
      step();
      if (pcFire) begin
        idx++;
        if (idx < 3) i_pc = pcs[idx];
        else i_pc_valid = 1'b0;
      end
      if (expectReq) begin
        checkOutput("b2b_no_bubble", {63'd0, o_mem_req_valid}, 64'd1);
        expectReq = 1'b0;
      end
    end
    checkOutput("b2b_count", 64'(got), 64'd3);
    idleInputs();
    step();

    // Flush during REQ: request completes, response is swallowed.
    startFetch(64'h8000_0000);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    #1;
    checkOutput("flreq_req_kept", {63'd0, o_mem_req_valid}, 64'd1);
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b1;
    step();
    i_mem_rsp_valid = 1'b0;
    #1;
    checkOutput("flreq_no_ins", {63'd0, o_ins_valid}, 64'd0);
    checkOutput("flreq_idle", {63'd0, o_pc_ready}, 64'd1);

    // Flush in WAIT with the response in the same cycle.
    startFetch(64'h8000_0008);
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_flush = 1'b1;
    i_mem_rsp_valid = 1'b1;
    step();
    i_flush = 1'b0;
    i_mem_rsp_valid = 1'b0;
    #1;
    checkOutput("flwait_no_ins", {63'd0, o_ins_valid}, 64'd0);
    checkOutput("flwait_idle", {63'd0, o_mem_rsp_ready}, 64'd0);

    // Flush in WAIT before the response; drop must also clear for the next fetch.
    startFetch(64'h8000_0010);
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    #1;
    checkOutput("flwait2_still_wait", {63'd0, o_mem_rsp_ready}, 64'd1);
    i_mem_rsp_valid = 1'b1;
    step();
    i_mem_rsp_valid = 1'b0;
    checkOutput("flwait2_no_ins", {63'd0, o_ins_valid}, 64'd0);
    applyStimulus(vecs[0]);

    // Flush in HOLD while decode is stalled.
    startFetch(64'h8000_0000);
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b1;
    i_mem_rdata = 64'h0010_0093_0000_0013;
    step();
    i_mem_rsp_valid = 1'b0;
    checkOutput("flhold_valid", {63'd0, o_ins_valid}, 64'd1);
    i_flush = 1'b1;
    i_pc_valid = 1'b1;
    #1;
    checkOutput("flhold_pc_blocked", {63'd0, o_pc_ready}, 64'd0);
    step();
    i_flush = 1'b0;
    i_pc_valid = 1'b0;
    #1;
    checkOutput("flhold_dropped", {63'd0, o_ins_valid}, 64'd0);
    checkOutput("flhold_no_req", {63'd0, o_mem_req_valid}, 64'd0);

    // Reset while waiting for a response; the late response is ignored.
    startFetch(64'h8000_0004);
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_rst = 1'b1;
    i_mem_rsp_valid = 1'b1;
    step();
    checkOutput("rstw_rsp_ready", {63'd0, o_mem_rsp_ready}, 64'd0);
    checkOutput("rstw_ins_valid", {63'd0, o_ins_valid}, 64'd0);
    checkOutput("rstw_ins_pc", o_ins_pc, 64'd0);
    checkOutput("rstw_mem_addr", o_mem_addr, 64'd0);
    checkOutput("rstw_ins_err", {62'd0, o_ins_err}, 64'd0);
    i_rst = 1'b0;
    step();
    checkOutput("rstw_rsp_ignored", {63'd0, o_ins_valid}, 64'd0);
    i_mem_rsp_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
